// File: rtl/scie_fir_pkg.sv
// Shared decode constants and FSM state type for the multi-channel SCIE FIR unit.
package scie_fir_pkg;

  localparam logic [6:0] OPC_COEF = 7'h0B;
  localparam logic [6:0] OPC_PUSH = 7'h2B;
  localparam logic [6:0] OPC_READ = 7'h3B;

  localparam logic [2:0] F3_COEF_WR = 3'd0;
  localparam logic [2:0] F3_CLEAR   = 3'd1;
  localparam logic [2:0] F3_PUSH    = 3'd0;
  localparam logic [2:0] F3_READ_LO = 3'd0;
  localparam logic [2:0] F3_READ_HI = 3'd1;

  // Bit position of the channel field inside rs2.
  localparam int CH_OFS = 16;

  typedef enum logic {
    IDLE,
    MAC
  } state_e;

endpackage

// File: rtl/fir_mac_unit.sv
// Single multiply-accumulate engine; sum_o is the running sum including the current term.
module fir_mac_unit #(
  parameter int COEF_W = 16,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 37,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [COEF_W-1:0] coef_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [ACC_W-1:0]  sum_o
);

  localparam int PROD_W = COEF_W + DATA_W;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_d, acc_q;

  if (SIGNED) begin : g_signed
    logic signed [PROD_W-1:0] prod;
    assign prod     = $signed(coef_i) * $signed(data_i);
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end else begin : g_unsigned
    logic [PROD_W-1:0] prod;
    assign prod     = coef_i * data_i;
    assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod};
  end

  assign sum_o = acc_q + prod_ext;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = sum_o;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/scie_fir_multi.sv
// Multi-channel FIR accelerator on the SCIE port: per-channel coefficient/delay banks, one sequential MAC.
module scie_fir_multi
  import scie_fir_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int TAPS     = 32,
  parameter int CHANNELS = 4,
  parameter bit SIGNED   = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_valid,
  output logic            io_ready,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic            io_rd_valid,
  output logic [XLEN-1:0] io_rd
);

  localparam int IDX_W = $clog2(TAPS);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W = DATA_W + COEF_W + IDX_W;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(TAPS - 1);

  state_e            state_d, state_q;
  logic [IDX_W-1:0]  k_d, k_q;
  logic [CH_W-1:0]   ch_d, ch_q;
  logic [COEF_W-1:0] coef_d [CHANNELS][TAPS];
  logic [COEF_W-1:0] coef_q [CHANNELS][TAPS];
  logic [DATA_W-1:0] x_d    [CHANNELS][TAPS];
  logic [DATA_W-1:0] x_q    [CHANNELS][TAPS];
  logic [ACC_W-1:0]  acc_d  [CHANNELS];
  logic [ACC_W-1:0]  acc_q  [CHANNELS];
  logic              rd_valid_d, rd_valid_q;
  logic [XLEN-1:0]   rd_d, rd_q;

  logic [6:0]       opc;
  logic [2:0]       f3;
  logic [CH_W-1:0]  ch_f;
  logic [IDX_W-1:0] idx_f;
  logic             accept, ch_ok, idx_ok;
  logic             mac_clr, mac_en;
  logic [ACC_W-1:0] mac_sum;
  logic [ACC_W+2*XLEN-1:0] rd_ext;
  logic             unused_ok;

  assign opc    = io_insn[6:0];
  assign f3     = io_insn[14:12];
  assign ch_f   = io_rs2[CH_OFS +: CH_W];
  assign idx_f  = io_rs2[IDX_W-1:0];
  assign accept = io_valid && io_ready;
  assign ch_ok  = 32'(ch_f) < 32'(CHANNELS);
  assign idx_ok = 32'(idx_f) < 32'(TAPS);
  assign unused_ok = ^{io_insn, io_rs1, io_rs2};

  // Extend the accumulator well past 2*XLEN so both READ halves are plain slices.
  assign rd_ext = {{(2*XLEN){SIGNED && acc_q[ch_f][ACC_W-1]}}, acc_q[ch_f]};

  fir_mac_unit #(
    .COEF_W(COEF_W),
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .SIGNED(SIGNED)
  ) u_mac (
    .clock (clock),
    .reset (reset),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .coef_i(coef_q[ch_q][k_q]),
    .data_i(x_q[ch_q][k_q]),
    .sum_o (mac_sum)
  );

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    ch_d       = ch_q;
    coef_d     = coef_q;
    x_d        = x_q;
    acc_d      = acc_q;
    rd_valid_d = 1'b0;
    rd_d       = '0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept && ch_ok) begin
          if (opc == OPC_COEF && f3 == F3_COEF_WR && idx_ok)
            coef_d[ch_f][idx_f] = io_rs1[COEF_W-1:0];
          if (opc == OPC_COEF && f3 == F3_CLEAR)
            for (int k = 0; k < TAPS; k++) x_d[ch_f][k] = '0;
          if (opc == OPC_PUSH && f3 == F3_PUSH) begin
            for (int k = TAPS - 1; k > 0; k--) x_d[ch_f][k] = x_q[ch_f][k-1];
            x_d[ch_f][0] = io_rs1[DATA_W-1:0];
            state_d = MAC;
            k_d     = '0;
            ch_d    = ch_f;
            mac_clr = 1'b1;
          end
        end
        if (accept && opc == OPC_READ && (f3 == F3_READ_LO || f3 == F3_READ_HI)) begin
          rd_valid_d = 1'b1;
          if (ch_ok)
            rd_d = (f3 == F3_READ_HI) ? rd_ext[2*XLEN-1:XLEN] : rd_ext[XLEN-1:0];
        end
      end
      MAC: begin
        mac_en = 1'b1;
        k_d    = k_q + 1'b1;
        if (k_q == K_LAST) begin
          acc_d[ch_q] = mac_sum;
          state_d     = IDLE;
          k_d         = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the banks are architectural state that must read as zero after reset, so they are reset too.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      ch_q       <= '0;
      coef_q     <= '{default: '0};
      x_q        <= '{default: '0};
      acc_q      <= '{default: '0};
      rd_valid_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      ch_q       <= ch_d;
      coef_q     <= coef_d;
      x_q        <= x_d;
      acc_q      <= acc_d;
      rd_valid_q <= rd_valid_d;
      rd_q       <= rd_d;
    end
  end

  assign io_ready    = (state_q == IDLE);
  assign io_rd_valid = rd_valid_q;
  assign io_rd       = rd_q;

endmodule

// File: tb/tb_scie_fir_multi.sv
// Drives an unsigned and a signed instance with identical traffic and checks both against a sum-of-products model.
module tb_scie_fir_multi;
  import scie_fir_pkg::*;

  localparam int TAPS     = 32;
  localparam int CHANNELS = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_valid = 1'b0;
  logic [31:0] io_insn = '0, io_rs1 = '0, io_rs2 = '0;
  logic        ready_u, ready_s, rdv_u, rdv_s;
  logic [31:0] rd_u, rd_s;

  always #5 clock = ~clock;

  scie_fir_multi #(.SIGNED(1'b0)) dut_u (
    .clock(clock), .reset(reset), .io_valid(io_valid), .io_ready(ready_u),
    .io_insn(io_insn), .io_rs1(io_rs1), .io_rs2(io_rs2),
    .io_rd_valid(rdv_u), .io_rd(rd_u)
  );

  scie_fir_multi #(.SIGNED(1'b1)) dut_s (
    .clock(clock), .reset(reset), .io_valid(io_valid), .io_ready(ready_s),
    .io_insn(io_insn), .io_rs1(io_rs1), .io_rs2(io_rs2),
    .io_rd_valid(rdv_s), .io_rd(rd_s)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] m_coef [CHANNELS][TAPS];
  logic [15:0] m_x    [CHANNELS][TAPS];
  longint      m_acc_u [CHANNELS];
  longint      m_acc_s [CHANNELS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < TAPS; k++) begin
        m_coef[c][k] = '0;
        m_x[c][k]    = '0;
      end
      m_acc_u[c] = 0;
      m_acc_s[c] = 0;
    end
  endtask

  task automatic m_push(input int ch, input logic [15:0] v);
    longint su = 0;
    longint ss = 0;
    for (int k = TAPS - 1; k > 0; k--) m_x[ch][k] = m_x[ch][k-1];
    m_x[ch][0] = v;
    for (int k = 0; k < TAPS; k++) begin
      su += longint'(m_coef[ch][k]) * longint'(m_x[ch][k]);
      ss += longint'($signed(m_coef[ch][k])) * longint'($signed(m_x[ch][k]));
    end
    m_acc_u[ch] = su;
    m_acc_s[ch] = ss;
  endtask

  function automatic logic [31:0] exp_u(input int ch, input bit hi);
    logic [63:0] t = m_acc_u[ch];
    return hi ? t[63:32] : t[31:0];
  endfunction

  function automatic logic [31:0] exp_s(input int ch, input bit hi);
    logic [63:0] t = m_acc_s[ch];
    return hi ? t[63:32] : t[31:0];
  endfunction

  function automatic logic [31:0] mk_insn(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] r = $urandom();
    r[6:0]   = opc;
    r[14:12] = f3;
    return r;
  endfunction

  function automatic logic [31:0] mk_rs2(input int ch, input int idx);
    logic [31:0] r = $urandom();
    r[17:16] = 2'(ch);
    r[4:0]   = 5'(idx);
    return r;
  endfunction

  // Offer one instruction at a negedge, hold it until accepted; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                      output int waited);
    waited   = 0;
    io_valid = 1'b1;
    io_insn  = insn;
    io_rs1   = rs1;
    io_rs2   = rs2;
    while (!ready_u) begin
      @(negedge clock);
      waited++;
      if (waited > 100) begin
        check("ready_timeout", 64'(ready_u), 64'd1);
        break;
      end
    end
    check("ready_match", 64'(ready_s), 64'(ready_u));
    @(posedge clock);
    @(negedge clock);
    io_valid = 1'b0;
  endtask

  task automatic coef_wr(input int ch, input int idx, input logic [15:0] v);
    int w;
    logic [31:0] rs1 = $urandom();
    rs1[15:0] = v;
    send(mk_insn(OPC_COEF, F3_COEF_WR), rs1, mk_rs2(ch, idx), w);
    m_coef[ch][idx] = v;
  endtask

  task automatic clear_ch(input int ch);
    int w;
    send(mk_insn(OPC_COEF, F3_CLEAR), $urandom(), mk_rs2(ch, $urandom_range(0, TAPS - 1)), w);
    for (int k = 0; k < TAPS; k++) m_x[ch][k] = '0;
  endtask

  task automatic push(input int ch, input logic [15:0] v);
    int w;
    logic [31:0] rs1 = $urandom();
    rs1[15:0] = v;
    send(mk_insn(OPC_PUSH, F3_PUSH), rs1, mk_rs2(ch, $urandom_range(0, TAPS - 1)), w);
    m_push(ch, v);
  endtask

  task automatic do_read(input string tag, input int ch, input bit hi,
                         output logic [31:0] got_u, output logic [31:0] got_s, output int waited);
    send(mk_insn(OPC_READ, hi ? F3_READ_HI : F3_READ_LO), $urandom(),
         mk_rs2(ch, $urandom_range(0, TAPS - 1)), waited);
    got_u = rd_u;
    got_s = rd_s;
    check({tag, "_vld_u"}, 64'(rdv_u), 64'd1);
    check({tag, "_vld_s"}, 64'(rdv_s), 64'd1);
    check({tag, "_u"}, 64'(rd_u), 64'(exp_u(ch, hi)));
    check({tag, "_s"}, 64'(rd_s), 64'(exp_s(ch, hi)));
    @(negedge clock);
    check({tag, "_pulse"}, 64'({rdv_u, rdv_s}), 64'd0);
  endtask

  task automatic bogus(input string tag, input logic [31:0] insn);
    int w;
    send(insn, $urandom(), $urandom(), w);
    check({tag, "_vld"}, 64'({rdv_u, rdv_s}), 64'd0);
    check({tag, "_rd"}, 64'(rd_u), 64'd0);
  endtask

  initial begin
    logic [31:0] gu, gs;
    int w;
    m_reset();

    repeat (3) @(negedge clock);
    check("rst_ready", 64'({ready_u, ready_s}), 64'b11);
    check("rst_rdv", 64'({rdv_u, rdv_s}), 64'd0);
    check("rst_rd", 64'(rd_u), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // Basic ch0 convolution.
    coef_wr(0, 0, 16'd36);
    coef_wr(0, 1, 16'd64);
    coef_wr(0, 2, 16'd76);
    coef_wr(0, 3, 16'd16);
    push(0, 16'd85);
    do_read("t1a", 0, 1'b0, gu, gs, w);
    check("t1a_lit", 64'(gu), 64'd3060);
    push(0, 16'd63);
    do_read("t1b", 0, 1'b0, gu, gs, w);
    check("t1b_lit", 64'(gu), 64'd7708);

    // Channel isolation.
    coef_wr(1, 0, 16'd2);
    push(1, 16'd10);
    do_read("t2_ch1", 1, 1'b0, gu, gs, w);
    check("t2_ch1_lit", 64'(gu), 64'd20);
    do_read("t2_ch0", 0, 1'b0, gu, gs, w);
    check("t2_ch0_lit", 64'(gu), 64'd7708);

    // A READ offered right behind a PUSH is held off for exactly TAPS cycles.
    push(0, 16'd7);
    do_read("t3", 0, 1'b0, gu, gs, w);
    check("t3_wait", 64'(w), 64'(TAPS));

    clear_ch(0);
    push(0, 16'd1);
    do_read("t4", 0, 1'b0, gu, gs, w);
    check("t4_lit", 64'(gu), 64'd36);

    // Sign handling on a fresh channel.
    coef_wr(3, 0, 16'hFFFF);
    push(3, 16'd5);
    do_read("t5lo", 3, 1'b0, gu, gs, w);
    check("t5lo_u_lit", 64'(gu), 64'h0004_FFFB);
    check("t5lo_s_lit", 64'(gs), 64'hFFFF_FFFB);
    do_read("t5hi", 3, 1'b1, gu, gs, w);
    check("t5hi_u_lit", 64'(gu), 64'd0);
    check("t5hi_s_lit", 64'(gs), 64'hFFFF_FFFF);

    bogus("bad_opc", mk_insn(7'h33, 3'd0));
    bogus("bad_rdf3", mk_insn(OPC_READ, 3'd2));
    bogus("bad_cf3", mk_insn(OPC_COEF, 3'd5));

    for (int n = 0; n < 80; n++) begin
      int op = $urandom_range(0, 9);
      int ch = $urandom_range(0, CHANNELS - 1);
      if (op <= 3)      coef_wr(ch, $urandom_range(0, TAPS - 1), 16'($urandom()));
      else if (op == 4) clear_ch(ch);
      else if (op <= 6) push(ch, 16'($urandom()));
      else if (op <= 8) do_read("rnd", ch, 1'($urandom()), gu, gs, w);
      else              bogus("rnd_bad", mk_insn(7'h5B, 3'($urandom())));
    end
    for (int c = 0; c < CHANNELS; c++) begin
      do_read("sweep_lo", c, 1'b0, gu, gs, w);
      do_read("sweep_hi", c, 1'b1, gu, gs, w);
    end

    // Reset in the middle of a MAC.
    push(1, 16'h1234);
    repeat (9) @(negedge clock);
    check("t6_busy", 64'(ready_u), 64'd0);
    reset = 1'b0;
    #1;
    check("t6_rst_ready", 64'({ready_u, ready_s}), 64'b11);
    @(negedge clock);
    reset = 1'b1;
    m_reset();
    @(negedge clock);
    check("t6_post_ready", 64'({ready_u, ready_s}), 64'b11);
    for (int c = 0; c < CHANNELS; c++) begin
      do_read("t6_lo", c, 1'b0, gu, gs, w);
      check("t6_lo_lit", 64'({gu, gs}), 64'd0);
    end
    push(0, 16'd99);
    do_read("t6_coef", 0, 1'b0, gu, gs, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scie_fir_multi.md
# scie_fir_multi

Parametrised multi-channel FIR accelerator behind the SCIE custom-instruction port. It is the successor to the single-channel 32-tap pipelined FIR unit. It adds per-channel coefficient and delay-line banks, generic widths and tap count, and signed/unsigned arithmetic. A single sequential MAC engine computes the outputs, and the core-facing interface uses a ready/valid handshake.

## Interface
Parameters:
- XLEN, 32: width of rs1/rs2/rd.
- DATA_W, 16: sample width, taken from rs1 LSBs.
- COEF_W, 16: coefficient width, taken from rs1 LSBs.
- TAPS, 32: taps per channel, ≥2.
- CHANNELS, 4: independent filters, ≥1.
- SIGNED, 0: 1 means samples, coefficients and accumulator are two's complement.

Derived values:
- IDX_W = clog2(TAPS)
- CH_W = max(1, clog2(CHANNELS))
- ACC_W = DATA_W + COEF_W + IDX_W

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- io_valid  in  1  instruction offered.
- io_ready  out  1  unit can accept an instruction.
- io_insn  in  32  instruction word.
- io_rs1  in  XLEN  operand 1.
- io_rs2  in  XLEN  operand 2.
- io_rd_valid  out  1  io_rd holds a result this cycle.
- io_rd  out  XLEN  result.

## Operation
- An instruction is accepted when io_valid && io_ready.
- Decode uses opcode insn[6:0] and funct3 insn[14:12].
- Channel field: ch = rs2[16+CH_W-1:16]. Index field: idx = rs2[IDX_W-1:0].
- COEF_WR (0x0B, f3=0): coef[ch][idx] ← rs1[COEF_W-1:0].
- CLEAR (0x0B, f3=1): every sample in delay line ch ← 0. Coefficients and result are kept.
- PUSH (0x2B, f3=0): shift delay line ch (x[k] ← x[k-1]), then x[0] ← rs1[DATA_W-1:0]. Start the MAC.
- READ (0x3B):
  - f3=0 returns acc[ch][XLEN-1:0].
  - f3=1 returns acc[ch] >> XLEN, sign-extended if SIGNED=1, else zero-extended.
- Any other encoding is accepted, has no effect and produces no io_rd_valid.
- Out-of-range ch (≥ CHANNELS) is accepted with no effect. A READ with out-of-range ch returns 0.
- MAC: acc[ch] = Σ_{k=0..TAPS-1} coef[ch][k]·x[ch][k], computed in ACC_W bits. It is exact, with no saturation.
- State machine: IDLE → (PUSH accepted) → MAC (TAPS cycles, k = 0..TAPS-1) → IDLE. All other instructions complete in IDLE.
- Reset state: all coefficients, samples and accumulators are 0; state is IDLE.

## Timing
- Output reset values: io_ready=1, io_rd_valid=0, io_rd=0.
- io_ready = (state==IDLE). It is low for exactly TAPS cycles after a PUSH is accepted.
- PUSH accepted at cycle T:
  - The delay line updates at the T edge.
  - MAC term k is computed in cycle T+1+k.
  - acc[ch] is written at the end of T+TAPS.
  - io_ready returns high at T+TAPS+1.
- READ accepted at T: io_rd_valid=1 and io_rd is valid at T+1 for one cycle only. Otherwise io_rd_valid=0 and io_rd=0.
- Back-to-back non-PUSH instructions are accepted every cycle.
- A READ on the cycle io_ready rises returns the new acc.
- Reset asserted mid-MAC: immediate return to the reset state. The partial sum is discarded and io_ready=1 after deassertion.
- io_valid while io_ready=0 is ignored. The core must hold the instruction.

## Structure
- Package scie_fir_pkg holds:
  - opcode constants: OPC_COEF=7'h0B, OPC_PUSH=7'h2B, OPC_READ=7'h3B;
  - funct3 constants;
  - the state enum {IDLE, MAC};
  - the channel-field offset 16.
- Sub-module fir_mac_unit:
  - one COEF_W×DATA_W multiplier plus ACC_W accumulator, with SIGNED handling;
  - driven with clear/enable/operands by the top-level FSM.
- The top level owns coefficient and sample storage, decode, the FSM and result registers.

## Test plan
1. Default parameters, ch0. Write coefficients 36, 64, 76, 16, … to idx 0..3, then PUSH 85 then READ → 3060. Then PUSH 63 then READ → 7708.
2. Channel isolation: coef[1][0]=2, PUSH 10 on ch1 → ch1 READ 20. ch0 READ is unchanged (7708).
3. Handshake: after a PUSH at T, io_ready=0 for cycles T+1..T+32. A READ offered at T+1 is held and accepted at T+33. It returns the new acc.
4. CLEAR ch0, then PUSH 1 → READ 36 (coef[0][0]·1 only).
5. SIGNED=1: coef[0][0]=0xFFFF, PUSH 5 → READ f3=0 returns 0xFFFFFFFB and READ f3=1 returns 0xFFFFFFFF. With SIGNED=0 the same stimulus gives 0x0004FFFB and 0.
6. Assert reset at T+10 of a MAC → io_ready=1, and READ of every channel returns 0 after release.
